// File: rtl/prince_pkg.sv
// rtl/prince_pkg.sv - shared widths, state encoding and default core latency for prince_ctrl
package prince_pkg;

  localparam int BLK_W        = 64;
  localparam int KEY_W        = 128;
  localparam int CORE_LAT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/prince_ctrl.sv
// rtl/prince_ctrl.sv - valid/ready sequencer around the PRINCE round core (optional PRINCE_CTRL_OPCNT_EN adds op_cnt)
module prince_ctrl
  import prince_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEF,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [0:BLK_W-1]   s_data,
  input  logic [0:KEY_W-1]   s_key,
  input  logic               s_dec,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [0:BLK_W-1]   m_data,
  output logic               core_st,
  output logic [0:BLK_W-1]   core_inp,
  output logic [0:KEY_W-1]   core_key,
  output logic               core_d,
  input  logic [0:BLK_W-1]   core_out
`ifdef PRINCE_CTRL_OPCNT_EN
  ,
  output logic [31:0]        op_cnt
`endif
);

  // Counter value seen on the edge where the core output is valid.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CORE_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:BLK_W-1] inp_q, inp_d;
  logic [0:KEY_W-1] key_q, key_d;
  logic             dec_q, dec_d;
  logic [0:BLK_W-1] res_q, res_d;
  // Low only until the first edge after reset release, so s_ready stays low during reset.
  logic             live_q;

  // State, counter and datapath registers; operand registers hold until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inp_q   <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      res_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inp_q   <= inp_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      res_q   <= res_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state and handshake outputs; core_out is only looked at on the capture edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inp_d   = inp_q;
    key_d   = key_q;
    dec_d   = dec_q;
    res_d   = res_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    core_st = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = live_q;
        if (s_valid && live_q) begin
          inp_d   = s_data;
          key_d   = s_key;
          dec_d   = s_dec;
          state_d = START;
        end
      end
      START: begin
        core_st = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          res_d   = core_out;
          state_d = DONE;
        end
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_data   = res_q;
  assign core_inp = inp_q;
  assign core_key = key_q;
  assign core_d   = dec_q;

`ifdef PRINCE_CTRL_OPCNT_EN
  logic [31:0] opcnt_q;

  // Completed-transfer counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) opcnt_q <= '0;
    else if (m_valid && m_ready) opcnt_q <= opcnt_q + 32'd1;
  end

  assign op_cnt = opcnt_q;
`endif

endmodule

// File: tb/tb_prince_ctrl.sv
// tb/tb_prince_ctrl.sv - scoreboard bench for prince_ctrl with a fixed-latency core stand-in
module tb_prince_ctrl;
  import prince_pkg::*;

  localparam int L = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, s_dec;
  logic [0:63]      s_data;
  logic [0:127]     s_key;
  logic             m_valid, m_ready;
  logic [0:63]      m_data;
  logic             core_st, core_d;
  logic [0:63]      core_inp, core_out;
  logic [0:127]     core_key;
`ifdef PRINCE_CTRL_OPCNT_EN
  logic [31:0]      op_cnt;
`endif

  always #5 clk = ~clk;

  prince_ctrl #(.CORE_LAT(L), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key), .s_dec(s_dec),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .core_st(core_st), .core_inp(core_inp), .core_key(core_key), .core_d(core_d),
    .core_out(core_out)
`ifdef PRINCE_CTRL_OPCNT_EN
    , .op_cnt(op_cnt)
`endif
  );

  // Block transform used by the core stand-in; direction matters so enc/dec differ.
  function automatic logic [0:63] core_fn(input logic [0:63] inp, input logic [0:127] key, input logic dec);
    logic [0:63] r;
    r = inp ^ key[0:63] ^ {key[96:127], key[64:95]};
    r = r + (dec ? 64'h0000_0000_0000_0001 : 64'h0123_0000_0000_0003);
    return {r[40:63], r[0:39]};
  endfunction

  // Core stand-in: result is valid only during the cycle before the L-th edge after st was sampled.
  int          age = 1000;
  logic [0:63] core_res = '0;
  always @(posedge clk) begin
    if (core_st) begin
      age      <= 0;
      core_res <= core_fn(core_inp, core_key, core_d);
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end
  assign core_out = (age == L - 1) ? core_res : ~core_res;

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [0:63] exp_q[$];
  int          acc_q[$];
  int          last_acc = 0;
  int          naccept = 0;
  int          nst = 0;
  int          nout = 0;
  int          mr_mode = 0;
  logic        mon_en = 1'b0;
  logic [0:63] lat_inp = '0;
  logic [0:127] lat_key = '0;
  logic        lat_dec = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at a negedge; presents a block and returns at the negedge after acceptance.
  task automatic send(input logic [0:63] d, input logic [0:127] k, input logic dc);
    bit ok;
    ok      = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_key   = k;
    s_dec   = dc;
    for (int i = 0; i < 300; i++) begin
      if (s_ready) begin
        exp_q.push_back(core_fn(d, k, dc));
        acc_q.push_back(cyc);
        last_acc = cyc;
        naccept++;
        @(posedge clk);
        lat_inp = d;
        lat_key = k;
        lat_dec = dc;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", s_ready, 1);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || m_valid); i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  always @(negedge clk) begin
    case (mr_mode)
      1:       m_ready = 1'($urandom % 2);
      2:       m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
  end

  logic        pmv = 1'b0, pmr = 1'b0, pst = 1'b0;
  logic [0:63] pmd = '0;

  // Monitor: scoreboard compare on each output handshake plus per-cycle protocol rules.
  always @(negedge clk) begin
    #2;
    if (rst_n && mon_en) begin
      if (core_st) nst++;
      if (core_st && pst) chk("core_st_one_cycle", core_st, 0);
      if (m_valid && !pmv) begin
        if (acc_q.size() == 0) chk("m_valid_without_accept", m_valid, 0);
        else chk("latency", cyc - acc_q.pop_front(), L + 2);
      end
      if (m_valid) chk("s_ready_low_while_valid", s_ready, 0);
      if (m_valid && pmv && !pmr) chk("m_data_stable", m_data, pmd);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("result_without_expect", m_valid, 0);
        else chk("m_data", m_data, exp_q.pop_front());
        nout++;
      end
      chk("core_inp_hold", core_inp, lat_inp);
      chk("core_key_hold", core_key, lat_key);
      chk("core_d_hold", core_d, lat_dec);
    end
    pmv = m_valid;
    pmr = m_ready;
    pmd = m_data;
    pst = core_st;
  end

  int a1, a2;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_key   = '0;
    s_dec   = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_core_st", core_st, 0);
    chk("rst_core_inp", core_inp, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_d", core_d, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("s_ready_after_release", s_ready, 1);

    send(64'h0, 128'h0, 1'b0);
    s_valid = 1'b0;
    send(64'h818665aa0d02dfda, 128'h0, 1'b1);
    s_valid = 1'b0;
    drain();

    // Backpressure: result must hold and new input must be ignored.
    mr_mode = 2;
    send(64'h0123456789abcdef, {64'h0123456789abcdef, 64'hfedcba9876543210}, 1'b0);
    s_valid = 1'b0;
    for (int i = 0; i < 50 && !m_valid; i++) @(negedge clk);
    chk("bp_m_valid_up", m_valid, 1);
    s_valid = 1'b1;
    s_data  = 64'hdeadbeefcafef00d;
    repeat (20) @(negedge clk);
    chk("bp_m_valid_held", m_valid, 1);
    chk("bp_no_accept", naccept, 3);
    s_valid = 1'b0;
    mr_mode = 0;
    drain();

    // Back-to-back with s_valid held high.
    send(64'hffffffffffffffff, 128'h0, 1'b0);
    a1 = last_acc;
    send(64'h0, {64'hffffffffffffffff, 64'h0}, 1'b0);
    a2 = last_acc;
    s_valid = 1'b0;
    chk("b2b_spacing", a2 - a1, L + 3);
    drain();

    // Reset in WAIT: in-flight result is discarded.
    send(64'h0, 128'h0, 1'b0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_inp = '0;
    lat_key = '0;
    lat_dec = 1'b0;
    nout    = 0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_core_inp", core_inp, 0);
    chk("abort_s_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 6) @(negedge clk);
    chk("abort_no_result", m_valid, 0);
    send(64'h0, 128'h0, 1'b0);
    s_valid = 1'b0;
    drain();

    // Randomised traffic with random backpressure and gaps.
    mr_mode = 1;
    for (int n = 0; n < 24; n++) begin
      send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom % 2));
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    mr_mode = 0;
    chk("core_st_count", nst, naccept);

`ifdef PRINCE_CTRL_OPCNT_EN
    chk("op_cnt", op_cnt, nout);
    rst_n = 1'b0;
    #1;
    chk("op_cnt_reset", op_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
